swatt_exec_ctrl: RTL

Execution controller for the secure attestation ROM (SMEM) on the MSP430 core. It defers interrupts while the PC is inside SMEM and releases them after a legal exit. It bounds attestation run time with a cycle watchdog and counts completed attestations. It sits beside the atomicity monitor: it filters irq before the CPU and drives its own fault reset into the core's reset OR-tree.

---
 rtl/swatt_exec_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/swatt_exec_ctrl.sv
// swatt_exec_ctrl: execution controller for the SMEM attestation ROM.
// Defers interrupts while the PC is inside SMEM and releases them after a
// legal exit. Illegal entry or exit raises fault_reset until the CPU reaches
// the reset handler. Completed attestations are counted with saturation.
//
// Optional feature macro: SWATT_WATCHDOG_EN
//   defined   - RUN is bounded by MAX_CYCLES clock cycles and then faults
//   undefined - no watchdog; the cycle counter (and MAX_CYCLES) do not exist
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   pc[15:0]     current CPU program counter
//   irq_in       raw level interrupt request
//   irq_ack      CPU interrupt acknowledge pulse
//   irq_out      gated interrupt request to the CPU (combinational)
//   busy         high while in RUN or EXIT
//   fault_reset  registered fault reset into the core reset tree
//   att_count    completed attestations, saturating at 8'hFF
module swatt_exec_ctrl #(
  parameter logic [15:0] SMEM_BASE      = 16'hE000,
  parameter logic [15:0] SMEM_SIZE      = 16'h1000,
  parameter logic [15:0] LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 16'd2,
  parameter logic [15:0] RESET_HANDLER  = 16'hFFFE
`ifdef SWATT_WATCHDOG_EN
  ,
  parameter logic [23:0] MAX_CYCLES     = 24'd2000000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        irq_in,
  input  logic        irq_ack,
  output logic        irq_out,
  output logic        busy,
  output logic        fault_reset,
  output logic [7:0]  att_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_EXIT  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  att_count_q, att_count_d;
  logic        fault_reset_q, fault_reset_d;
  logic        busy_q, busy_d;

  logic        in_smem_c, is_first_c, is_last_c;
  logic        wd_expire_c;
  logic        fault_entry_c;

  // Address decode
  assign in_smem_c  = (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR);
  assign is_first_c = (pc == SMEM_BASE);
  assign is_last_c  = (pc == LAST_SMEM_ADDR);

`ifdef SWATT_WATCHDOG_EN
  logic [23:0] cycle_cnt_q, cycle_cnt_d;

  assign wd_expire_c = (cycle_cnt_q == (MAX_CYCLES - 24'd1));

  // Cycle counter: restarts on entry, counts while RUN is held, never wraps
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == S_IDLE && is_first_c) begin
      cycle_cnt_d = '0;
    end else if (state_q == S_RUN && state_d == S_RUN && cycle_cnt_q != MAX_CYCLES) begin
      cycle_cnt_d = cycle_cnt_q + 24'd1;
    end
    if (fault_entry_c) begin
      cycle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end
`else
  assign wd_expire_c = 1'b0;
`endif

  // Next-state logic; in RUN, leaving SMEM outranks the watchdog, which outranks the exit
  always_comb begin
    state_d     = state_q;
    att_count_d = att_count_q;
    case (state_q)
      S_IDLE: begin
        if (is_first_c) begin
          state_d = S_RUN;
        end else if (in_smem_c) begin
          state_d = S_FAULT;
        end
      end
      S_RUN: begin
        if (!in_smem_c) begin
          state_d = S_FAULT;
        end else if (wd_expire_c) begin
          state_d = S_FAULT;
        end else if (is_last_c) begin
          state_d = S_EXIT;
        end
      end
      S_EXIT: begin
        if (!in_smem_c) begin
          state_d = S_IDLE;
          if (att_count_q != 8'hFF) begin
            att_count_d = att_count_q + 8'd1;
          end
        end else if (!is_last_c) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (pc == RESET_HANDLER) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fault_entry_c = (state_d == S_FAULT) && (state_q != S_FAULT);

  // Deferred-interrupt latch: set beats ack, fault entry clears it
  always_comb begin
    pending_d = pending_q;
    if (irq_in && (in_smem_c || state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end else if (irq_ack) begin
      pending_d = 1'b0;
    end
    if (fault_entry_c) begin
      pending_d = 1'b0;
    end
    fault_reset_d = (state_d == S_FAULT);
    busy_d        = (state_d == S_RUN) || (state_d == S_EXIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pending_q     <= 1'b0;
      att_count_q   <= 8'd0;
      fault_reset_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      att_count_q   <= att_count_d;
      fault_reset_q <= fault_reset_d;
      busy_q        <= busy_d;
    end
  end

  // Zero-latency mask: nothing reaches the CPU while pc is in SMEM
  assign irq_out     = (irq_in | pending_q) & (state_q == S_IDLE) & ~in_smem_c;
  assign busy        = busy_q;
  assign fault_reset = fault_reset_q;
  assign att_count   = att_count_q;

endmodule
